vga_timing_gen: RTL and testbench

//  Consumer end of the VGA pixel-clock PLL: runs on the 25 MHz PLL output clock and

---
 rtl/vga_timing_gen.sv | 166 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator on the PLL pixel clock. Holds the raster idle until the
// synchronised PLL lock has been stable for LOCK_SETTLE cycles, restarts from (0,0) on relock.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter bit          SYNC_POL    = 1'b0,
  parameter int unsigned LOCK_SETTLE = 16,
  parameter int unsigned CW          = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pll_locked,
  input  logic          lock_err_clr,
  output logic          hsync,
  output logic          vsync,
  output logic          blank_n,
  output logic          pix_req,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start,
  output logic          running,
  output logic          lock_lost
);

  localparam int unsigned H_TOTAL   = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL   = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_SYNC_LO = H_ACTIVE + H_FRONT;
  localparam int unsigned H_SYNC_HI = H_ACTIVE + H_FRONT + H_SYNC;
  localparam int unsigned V_SYNC_LO = V_ACTIVE + V_FRONT;
  localparam int unsigned V_SYNC_HI = V_ACTIVE + V_FRONT + V_SYNC;
  localparam int unsigned SW        = (LOCK_SETTLE > 1) ? $clog2(LOCK_SETTLE) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_RUN} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          lock_meta_q, lock_meta_d, locked_s_q, locked_s_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          blank_n_q, blank_n_d, pix_req_q, pix_req_d;
  logic          line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic          running_q, running_d, lock_lost_q, lock_lost_d;
  logic [2*CW-1:0] cur_step, nxt_step;

  function automatic logic in_active(input logic [CW-1:0] h, input logic [CW-1:0] v);
    return (h < CW'(H_ACTIVE)) && (v < CW'(V_ACTIVE));
  endfunction

  // Raster position one pixel after (h, v), wrapping line and frame.
  function automatic logic [2*CW-1:0] step_pos(input logic [CW-1:0] h, input logic [CW-1:0] v);
    logic [CW-1:0] nh, nv;
    nh = h + CW'(1);
    nv = v;
    if (h == CW'(H_TOTAL - 1)) begin
      nh = '0;
      nv = (v == CW'(V_TOTAL - 1)) ? '0 : v + CW'(1);
    end
    return {nh, nv};
  endfunction

  assign cur_step = step_pos(x_q, y_q);
  assign nxt_step = step_pos(x_d, y_d);

  // Lock synchroniser, state and raster position.
  always_comb begin
    lock_meta_d = pll_locked;
    locked_s_d  = lock_meta_q;
    state_d     = state_q;
    cnt_d       = '0;
    x_d         = '0;
    y_d         = '0;
    case (state_q)
      ST_IDLE: begin
        if (locked_s_q) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!locked_s_q)                           state_d = ST_IDLE;
        else if (cnt_q == SW'(LOCK_SETTLE - 1))    state_d = ST_RUN;
        else                                       cnt_d   = cnt_q + SW'(1);
      end
      ST_RUN: begin
        if (!locked_s_q) state_d = ST_IDLE;
        else             {x_d, y_d} = cur_step;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs describe the pixel the raster shows after this edge.
  always_comb begin
    hsync_d       = ~SYNC_POL;
    vsync_d       = ~SYNC_POL;
    blank_n_d     = 1'b0;
    pix_req_d     = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    running_d     = 1'b0;
    lock_lost_d   = lock_lost_q;
    if (state_d == ST_RUN) begin
      blank_n_d     = in_active(x_d, y_d);
      pix_req_d     = in_active(nxt_step[2*CW-1:CW], nxt_step[CW-1:0]);
      hsync_d       = (x_d >= CW'(H_SYNC_LO) && x_d < CW'(H_SYNC_HI)) ? SYNC_POL : ~SYNC_POL;
      vsync_d       = (y_d >= CW'(V_SYNC_LO) && y_d < CW'(V_SYNC_HI)) ? SYNC_POL : ~SYNC_POL;
      line_start_d  = (x_d == '0);
      frame_start_d = (x_d == '0) && (y_d == '0);
      running_d     = 1'b1;
    end else if (state_d == ST_SETTLE && cnt_d == SW'(LOCK_SETTLE - 1)) begin
      pix_req_d = in_active('0, '0);
    end
    if (state_q == ST_RUN && !locked_s_q) lock_lost_d = 1'b1;
    else if (lock_err_clr)                lock_lost_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_meta_q   <= 1'b0;
      locked_s_q    <= 1'b0;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      blank_n_q     <= 1'b0;
      pix_req_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      running_q     <= 1'b0;
      lock_lost_q   <= 1'b0;
    end else begin
      lock_meta_q   <= lock_meta_d;
      locked_s_q    <= locked_s_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_n_q     <= blank_n_d;
      pix_req_q     <= pix_req_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      running_q     <= running_d;
      lock_lost_q   <= lock_lost_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank_n     = blank_n_q;
  assign pix_req     = pix_req_q;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign running     = running_q;
  assign lock_lost   = lock_lost_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced 30x17 raster: hand table, frame statistics,
// lock-loss sequences and randomized lock activity against a position-from-streak model.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 4, HS = 6, HB = 4;
  localparam int VA = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int LS = 16;
  localparam int CW = 10;
  localparam bit SP = 1'b0;

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          bl;
    logic          pr;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          ls;
    logic          fs;
    logic          run;
    logic          lost;
  } out_t;

  typedef struct {
    int   edge_n;
    out_t exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pll_locked = 1'b0;
  logic          lock_err_clr = 1'b0;
  logic          hsync, vsync, blank_n, pix_req;
  logic [CW-1:0] pixel_x, pixel_y;
  logic          line_start, frame_start, running, lock_lost;

  int n_err = 0;
  int n_checks = 0;

  // Model: streak of consecutive edges that saw the synchronised lock high.
  int m_streak = 0;
  bit m_sync0 = 0, m_sync1 = 0, m_lost = 0;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(SP), .LOCK_SETTLE(LS), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .lock_err_clr(lock_err_clr),
    .hsync(hsync), .vsync(vsync), .blank_n(blank_n), .pix_req(pix_req),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .line_start(line_start),
    .frame_start(frame_start), .running(running), .lock_lost(lock_lost)
  );

  always #5 clk = ~clk;

  function automatic out_t mk(logic hs, logic vs, logic bl, logic pr, int x, int y,
                              logic ls, logic fs, logic run);
    out_t o;
    o.hs = hs; o.vs = vs; o.bl = bl; o.pr = pr;
    o.x = CW'(x); o.y = CW'(y);
    o.ls = ls; o.fs = fs; o.run = run; o.lost = 1'b0;
    return o;
  endfunction

  function automatic logic act(int x, int y);
    return (x < HA) && (y < VA);
  endfunction

  function automatic out_t get_out();
    return {hsync, vsync, blank_n, pix_req, pixel_x, pixel_y,
            line_start, frame_start, running, lock_lost};
  endfunction

  function automatic out_t expect_vec();
    out_t e;
    int p, q, x, y;
    e = mk(!SP, !SP, 0, 0, 0, 0, 0, 0, 0);
    if (m_streak >= LS) begin
      q = m_streak - LS;
      e.pr = act(q % HT, (q / HT) % VT);
    end
    if (m_streak >= LS + 1) begin
      p = m_streak - LS - 1;
      x = p % HT;
      y = (p / HT) % VT;
      e.x   = CW'(x);
      e.y   = CW'(y);
      e.bl  = act(x, y);
      e.hs  = (x >= HA + HF && x < HA + HF + HS) ? SP : !SP;
      e.vs  = (y >= VA + VF && y < VA + VF + VS) ? SP : !SP;
      e.ls  = (x == 0);
      e.fs  = (x == 0) && (y == 0);
      e.run = 1'b1;
    end
    e.lost = m_lost;
    return e;
  endfunction

  task automatic model_step();
    bit s, was_run;
    if (rst) begin
      m_streak = 0; m_sync0 = 0; m_sync1 = 0; m_lost = 0;
      return;
    end
    s       = m_sync1;
    was_run = (m_streak >= LS + 1);
    m_sync1 = m_sync0;
    m_sync0 = pll_locked;
    if (was_run && !s)      m_lost = 1;
    else if (lock_err_clr)  m_lost = 0;
    m_streak = s ? m_streak + 1 : 0;
  endtask

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("model", get_out(), expect_vec());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pll_locked = 1'b0;
    lock_err_clr = 1'b0;
    repeat (3) cycle();
    rst = 1'b0;
    pll_locked = 1'b1;
  endtask

  vec_t tbl[17];
  int   n;
  logic prev_pr;
  int   bl_cnt, hs_cnt, vs_cnt, fs_cnt, last_fs;

  initial begin
    // Edge numbers count from the first edge that samples pll_locked high.
    tbl[0]  = '{0,   mk(1, 1, 0, 0, 0,  0,  0, 0, 0)};
    tbl[1]  = '{18,  mk(1, 1, 0, 1, 0,  0,  0, 0, 0)};
    tbl[2]  = '{19,  mk(1, 1, 1, 1, 0,  0,  1, 1, 1)};
    tbl[3]  = '{20,  mk(1, 1, 1, 1, 1,  0,  0, 0, 1)};
    tbl[4]  = '{34,  mk(1, 1, 1, 0, 15, 0,  0, 0, 1)};
    tbl[5]  = '{35,  mk(1, 1, 0, 0, 16, 0,  0, 0, 1)};
    tbl[6]  = '{39,  mk(0, 1, 0, 0, 20, 0,  0, 0, 1)};
    tbl[7]  = '{45,  mk(1, 1, 0, 0, 26, 0,  0, 0, 1)};
    tbl[8]  = '{48,  mk(1, 1, 0, 1, 29, 0,  0, 0, 1)};
    tbl[9]  = '{49,  mk(1, 1, 1, 1, 0,  1,  1, 0, 1)};
    tbl[10] = '{289, mk(1, 1, 1, 1, 0,  9,  1, 0, 1)};
    tbl[11] = '{318, mk(1, 1, 0, 0, 29, 9,  0, 0, 1)};
    tbl[12] = '{379, mk(1, 0, 0, 0, 0,  12, 1, 0, 1)};
    tbl[13] = '{439, mk(1, 1, 0, 0, 0,  14, 1, 0, 1)};
    tbl[14] = '{528, mk(1, 1, 0, 1, 29, 16, 0, 0, 1)};
    tbl[15] = '{529, mk(1, 1, 1, 1, 0,  0,  1, 1, 1)};
    tbl[16] = '{530, mk(1, 1, 1, 1, 1,  0,  0, 0, 1)};

    do_reset();
    n = 0;
    for (int i = 0; i < 17; i++) begin
      while (n < tbl[i].edge_n) begin
        cycle();
        n++;
      end
      chk($sformatf("table[%0d]", i), get_out(), tbl[i].exp);
    end

    // Two free-running frames: pix_req leads blank_n by one cycle, frame statistics.
    prev_pr = pix_req;
    bl_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; last_fs = -1;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      cycle();
      chk("pixreq_lead", blank_n, prev_pr);
      prev_pr = pix_req;
      bl_cnt += int'(blank_n);
      hs_cnt += int'(hsync == SP);
      vs_cnt += int'(vsync == SP);
      if (frame_start) begin
        if (last_fs >= 0) chk("frame_period", 64'(i - last_fs), 64'(HT * VT));
        last_fs = i;
        fs_cnt++;
      end
    end
    chk("frame_count", 64'(fs_cnt), 64'd2);
    chk("blank_count", 64'(bl_cnt), 64'(2 * HA * VA));
    chk("hsync_count", 64'(hs_cnt), 64'(2 * VT * HS));
    chk("vsync_count", 64'(vs_cnt), 64'(2 * VS * HT));

    // Lock loss mid-frame at (10,5); clear coinciding with the loss must not win.
    for (int k = 0; k < 600 && !(pixel_x == 10 && pixel_y == 5); k++) cycle();
    chk("t5_reach", {pixel_x, pixel_y}, {10'd10, 10'd5});
    pll_locked = 1'b0;
    cycle();
    cycle();
    chk("t5_still_run", running, 1'b1);
    lock_err_clr = 1'b1;
    cycle();
    lock_err_clr = 1'b0;
    chk("t5_drop", {running, lock_lost, blank_n, hsync, vsync}, 5'b01011);
    pll_locked = 1'b1;
    repeat (LS + 2) cycle();
    chk("t5_pre_restart", running, 1'b0);
    cycle();
    chk("t5_restart", {running, frame_start, pixel_x, pixel_y, lock_lost},
        {1'b1, 1'b1, 10'd0, 10'd0, 1'b1});
    repeat (5) cycle();
    chk("t5_lost_held", lock_lost, 1'b1);
    lock_err_clr = 1'b1;
    cycle();
    lock_err_clr = 1'b0;
    chk("t5_lost_clr", lock_lost, 1'b0);

    // One-cycle lock glitch during settle restarts the settle window.
    do_reset();
    repeat (8) cycle();
    pll_locked = 1'b0;
    cycle();
    pll_locked = 1'b1;
    repeat (10) cycle();
    chk("t6_no_run", {running, lock_lost}, 2'b00);
    for (int k = 0; k < 40 && !running; k++) cycle();
    chk("t6_late_run", {running, frame_start, pixel_x, pixel_y},
        {1'b1, 1'b1, 10'd0, 10'd0});
    repeat (100) cycle();
    rst = 1'b1;
    #1;
    chk("t6_async_rst", get_out(), mk(!SP, !SP, 0, 0, 0, 0, 0, 0, 0));
    cycle();
    rst = 1'b0;

    // Randomized lock drops, glitches and clears.
    for (int i = 0; i < 8000; i++) begin
      cycle();
      lock_err_clr = ($urandom_range(0, 49) == 0);
      if (pll_locked) pll_locked = !($urandom_range(0, 599) == 0);
      else            pll_locked = ($urandom_range(0, 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
